sram_controller: RTL and testbench
==================================

# sram_controller

Bus initiator that drives the external 16-bit asynchronous SRAM on behalf of the MEM stage. It accepts the 32-bit word read/write requests the MEM stage issues (mem_r_en/mem_w_en, address, write_data) and splits each into two 16-bit SRAM accesses. It reassembles read words and holds ready low so the pipeline freezes until the access completes. Word layout is big-endian, matching the data memory it replaces: the most significant half of each word sits at the lower SRAM halfword address.

## Interface
Parameters:
- BASE_ADDR, 1024: byte address of SRAM word 0; subtracted from address before mapping.
- ACCESS_CYCLES, 2: clock cycles each 16-bit half-access is held on the SRAM pins (legal range 1..15).

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_r_en  in  1  word read request.
- mem_w_en  in  1  word write request; wins if both are asserted.
- address  in  32  byte address of the request.
- write_data  in  32  write word.
- read_data  out  32  last completed read word, registered.
- ready  out  1  high when no access is in progress; low freezes the pipeline.
- sram_addr  out  18  SRAM halfword address.
- sram_dq  inout  16  SRAM data; driven only in write states, otherwise high-Z.
- sram_we_n  out  1  active-low write strobe.
- sram_oe_n  out  1  active-low output enable.
- sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  tied 0.

## Operation
- States: IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE. A 4-bit phase counter counts 0..ACCESS_CYCLES-1 inside each HI/LO state.
- IDLE, request present at the clock edge:
  - Latch word index = (address - BASE_ADDR) >> 2, truncated to 17 bits. Out-of-range addresses wrap; address[1:0] is ignored.
  - Latch write_data.
  - Go to WR_HI if mem_w_en, else RD_HI.
- IDLE, no request: stay in IDLE.
- Phase transitions, each taken when the counter reaches ACCESS_CYCLES-1:
  - HI state to matching LO state.
  - RD_LO or WR_LO to DONE.
- DONE to IDLE unconditionally.
- sram_addr:
  - HI states: {index, 1'b0}.
  - LO states: {index, 1'b1}.
  - IDLE and DONE: 0.
- Write phases:
  - sram_we_n = 0 and sram_oe_n = 1.
  - sram_dq = latched data[31:16] in WR_HI, latched data[15:0] in WR_LO.
- Read phases:
  - sram_oe_n = 0 and sram_we_n = 1; sram_dq high-Z.
  - sram_dq is sampled on the last cycle of RD_HI into hi[15:0] and on the last cycle of RD_LO into lo[15:0].
  - read_data <= {hi, lo} on the RD_LO to DONE edge.
- Other states: sram_we_n = sram_oe_n = 1 and sram_dq high-Z.
- ready = (state==IDLE & ~mem_r_en & ~mem_w_en) | (state==DONE). It is combinational from the registered state and the request inputs.
- Request inputs may change or drop after latching. The operation started in IDLE always runs to DONE, and ready stays low until DONE.
- read_data is unchanged by writes and holds its value until the next read completes.

## Timing
- Reset: state = IDLE and counter = 0. read_data = 0, sram_addr = 0, sram_we_n = sram_oe_n = 1, sram_dq high-Z. ready = 1 when no request is present.
- Reset mid-operation aborts immediately: the next cycle is IDLE with all the above values, and no further SRAM strobe is issued.
- Request first seen in cycle 0:
  - ready is low from cycle 0, combinationally.
  - HI occupies cycles 1..A and LO occupies cycles A+1..2A, where A = ACCESS_CYCLES.
  - DONE occurs in cycle 2A+1, with ready high. The pipeline advances at the end of that cycle.
- Total latency is 2·ACCESS_CYCLES+2 cycles; with the default, 6 cycles (ready high in cycle 5).
- Back-to-back requests: a request present in the cycle after DONE is treated as new and starts from IDLE. There is no repeat of the finished request because the pipeline has advanced.
- Simultaneous mem_r_en and mem_w_en: a write is performed and read_data is unchanged.

## Test plan
- Reset then idle, no request: ready=1, read_data=0, sram_we_n=sram_oe_n=1, sram_dq=Z for 10 cycles.
- Write 0xDEADBEEF to address 1024+8, then read the same address (SRAM behavioural model attached):
  - Write phase: halfword 4 = 0xDEAD and halfword 5 = 0xBEEF; sram_we_n is low for exactly 2+2 cycles.
  - ready is low for cycles 0-4 and high in cycle 5.
  - Read phase: read_data = 0xDEADBEEF after DONE.
- ACCESS_CYCLES=1, read address 1024 with the model preloaded 0x1234/0x5678: ready high in cycle 3, read_data = 0x12345678.
- mem_r_en and mem_w_en both high with write_data=0x0000FFFF: SRAM halfwords receive 0x0000/0xFFFF and read_data keeps its previous value.
- Address 1024 + 4·2^17 (wrap): sram_addr = 0 then 1.
- reset asserted in cycle 2 of a write: next cycle is IDLE, sram_we_n=1, sram_dq=Z, and only the already-strobed HI halfword is modified.

Source files
------------

// File: rtl/sram_controller_if.sv
// MEM-stage word request bus between the pipeline and the SRAM controller.
// The master is the pipeline; the slave is the controller that answers with ready/read_data.
interface sram_controller_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output mem_r_en,
        output mem_w_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  mem_r_en,
        input  mem_w_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage word accesses into two 16-bit accesses on an async SRAM.
// Big-endian layout: the high half of each word lives at the even halfword address.
module sram_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    sram_controller_if.slave  bus,
    output logic [17:0]       sram_addr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_HI = 3'd1;
    localparam logic [2:0] S_RD_LO = 3'd2;
    localparam logic [2:0] S_WR_HI = 3'd3;
    localparam logic [2:0] S_WR_LO = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0]  PHASE_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [31:0] BASE       = 32'(BASE_ADDR);

    logic [2:0]  r_state;
    logic [3:0]  r_phase;
    logic [16:0] r_index;
    logic [31:0] r_wdata;
    logic [15:0] r_hi;
    logic [31:0] r_read_data;
    logic [17:0] r_addr;
    logic        r_we_n;
    logic        r_oe_n;
    logic        r_dq_oe;
    logic [15:0] r_dq_out;

    logic [2:0]  w_state_next;
    logic        w_req;
    logic        w_last;
    logic        w_in_phase;
    logic [31:0] w_offset;
    logic [16:0] w_index;
    logic [31:0] w_wdata;
    logic [17:0] w_addr_next;
    logic        w_we_n_next;
    logic        w_oe_n_next;
    logic        w_dq_oe_next;
    logic [15:0] w_dq_out_next;
    logic        w_unused_offset_bits;

    assign w_req      = bus.mem_r_en | bus.mem_w_en;
    assign w_last     = (r_phase == PHASE_LAST);
    assign w_in_phase = (r_state == S_RD_HI) || (r_state == S_RD_LO) ||
                        (r_state == S_WR_HI) || (r_state == S_WR_LO);

    // Word index wraps modulo 2^17; byte-lane bits and the upper address bits are dropped.
    assign w_offset             = bus.address - BASE;
    assign w_unused_offset_bits = ^{w_offset[31:19], w_offset[1:0]};

    // In IDLE the request is being latched this edge, so the pin values must come from the bus.
    assign w_index = (r_state == S_IDLE) ? w_offset[18:2] : r_index;
    assign w_wdata = (r_state == S_IDLE) ? bus.write_data : r_wdata;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next = bus.mem_w_en ? S_WR_HI : S_RD_HI;
                end
            end
            S_RD_HI: if (w_last) w_state_next = S_RD_LO;
            S_RD_LO: if (w_last) w_state_next = S_DONE;
            S_WR_HI: if (w_last) w_state_next = S_WR_LO;
            S_WR_LO: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered, so strobes never glitch.
    always_comb begin
        w_addr_next   = '0;
        w_we_n_next   = 1'b1;
        w_oe_n_next   = 1'b1;
        w_dq_oe_next  = 1'b0;
        w_dq_out_next = '0;
        case (w_state_next)
            S_RD_HI: begin
                w_addr_next = {w_index, 1'b0};
                w_oe_n_next = 1'b0;
            end
            S_RD_LO: begin
                w_addr_next = {w_index, 1'b1};
                w_oe_n_next = 1'b0;
            end
            S_WR_HI: begin
                w_addr_next   = {w_index, 1'b0};
                w_we_n_next   = 1'b0;
                w_dq_oe_next  = 1'b1;
                w_dq_out_next = w_wdata[31:16];
            end
            S_WR_LO: begin
                w_addr_next   = {w_index, 1'b1};
                w_we_n_next   = 1'b0;
                w_dq_oe_next  = 1'b1;
                w_dq_out_next = w_wdata[15:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= 4'd0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_hi        <= '0;
            r_read_data <= '0;
            r_addr      <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= (w_in_phase && !w_last) ? r_phase + 4'd1 : 4'd0;

            if (r_state == S_IDLE && w_req) begin
                r_index <= w_index;
                r_wdata <= bus.write_data;
            end

            // Read data is sampled on the last cycle of each half, when it has settled longest.
            if (r_state == S_RD_HI && w_last) begin
                r_hi <= sram_dq;
            end
            if (r_state == S_RD_LO && w_last) begin
                r_read_data <= {r_hi, sram_dq};
            end

            r_addr   <= w_addr_next;
            r_we_n   <= w_we_n_next;
            r_oe_n   <= w_oe_n_next;
            r_dq_oe  <= w_dq_oe_next;
            r_dq_out <= w_dq_out_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_dq
            assign sram_dq[gi] = r_dq_oe ? r_dq_out[gi] : 1'bz;
        end
    endgenerate

    assign sram_addr     = r_addr;
    assign sram_we_n     = r_we_n;
    assign sram_oe_n     = r_oe_n;
    assign sram_ce_n     = 1'b0;
    assign sram_ub_n     = 1'b0;
    assign sram_lb_n     = 1'b0;

    assign bus.read_data = r_read_data;
    assign bus.ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (ACCESS_CYCLES 2 and 1),
// each with a behavioural async SRAM that captures writes mid-cycle.
module tb_sram_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_controller_if bus0 ();
    sram_controller_if bus1 ();

    wire  [15:0] dq0;
    wire  [15:0] dq1;
    logic [17:0] a0, a1;
    logic        we0, oe0, ce0, ub0, lb0;
    logic        we1, oe1, ce1, ub1, lb1;
    logic        probe_en = 1'b0;
    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];
    int          we_low0 = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [17:0] addr_log [0:39];

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus0),
        .sram_addr (a0),
        .sram_dq   (dq0),
        .sram_we_n (we0),
        .sram_oe_n (oe0),
        .sram_ce_n (ce0),
        .sram_ub_n (ub0),
        .sram_lb_n (lb0)
    );

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus1),
        .sram_addr (a1),
        .sram_dq   (dq1),
        .sram_we_n (we1),
        .sram_oe_n (oe1),
        .sram_ce_n (ce1),
        .sram_ub_n (ub1),
        .sram_lb_n (lb1)
    );

    // SRAM drives on reads; the probe pulls the bus to 0 so a stray controller drive shows up.
    assign dq0 = (!oe0 && we0) ? mem0[a0[7:0]] : (probe_en ? 16'h0000 : 16'hzzzz);
    assign dq1 = (!oe1 && we1) ? mem1[a1[7:0]] : 16'hzzzz;

    always @(negedge clock) begin
        if (!we0) begin
            mem0[a0[7:0]] <= dq0;
            we_low0       <= we_low0 + 1;
        end
        if (!we1) begin
            mem1[a1[7:0]] <= dq1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.mem_w_en = w; bus0.mem_r_en = r; bus0.address = a; bus0.write_data = d;
        end else begin
            bus1.mem_w_en = w; bus1.mem_r_en = r; bus1.address = a; bus1.write_data = d;
        end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? bus0.ready : bus1.ready;
    endfunction

    // Presents a request in cycle 0, returns the first cycle with ready high (-1 on timeout),
    // then drops the request after the pipeline would have advanced.
    task automatic op(input int sel, input logic w, input logic r, input logic [31:0] addr,
                      input logic [31:0] wd, output int rdy_cycle);
        rdy_cycle = -1;
        drive(sel, w, r, addr, wd);
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            addr_log[cyc] = (sel == 0) ? a0 : a1;
            if (ready_of(sel)) begin
                rdy_cycle = cyc;
                break;
            end
            tick();
        end
        tick();
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("op inst=%0d w=%0d r=%0d addr=0x%08h wdata=0x%08h ready_cycle=%0d rdata=0x%08h",
                 sel, w, r, addr, wd, rdy_cycle,
                 (sel == 0) ? bus0.read_data : bus1.read_data);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int w0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset
        probe_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_ready", 32'(bus0.ready), 32'd1);
            check("idle_strobes", 32'({we0, oe0, ce0, ub0, lb0}), 32'b11000);
            check("idle_rdata", bus0.read_data, 32'h0);
            check("idle_dq", 32'(dq0), 32'h0);
            check("idle_addr", 32'(a0), 32'h0);
            tick();
        end
        probe_en = 1'b0;
        check("idle_rdata_a1", bus1.read_data, 32'h0);
        check("idle_ready_a1", 32'(bus1.ready), 32'd1);

        // Write then read 0xDEADBEEF at 1024+8 (halfwords 4/5)
        w0 = we_low0;
        op(0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, rc);
        check("wr_ready_cycle", 32'(rc), 32'd5);
        check("wr_we_low_cycles", 32'(we_low0 - w0), 32'd4);
        check("wr_hw4", 32'(mem0[4]), 32'h0000DEAD);
        check("wr_hw5", 32'(mem0[5]), 32'h0000BEEF);
        check("wr_addr_hi", 32'(addr_log[1]), 32'd4);
        check("wr_addr_lo", 32'(addr_log[3]), 32'd5);
        check("wr_rdata_kept", bus0.read_data, 32'h0);
        op(0, 1'b0, 1'b1, 32'd1032, 32'h0, rc);
        check("rd_ready_cycle", 32'(rc), 32'd5);
        check("rd_rdata", bus0.read_data, 32'hDEADBEEF);

        // ACCESS_CYCLES=1 instance
        op(1, 1'b1, 1'b0, 32'd1024, 32'h12345678, rc);
        check("a1_wr_ready_cycle", 32'(rc), 32'd3);
        check("a1_hw0", 32'(mem1[0]), 32'h00001234);
        check("a1_hw1", 32'(mem1[1]), 32'h00005678);
        op(1, 1'b0, 1'b1, 32'd1024, 32'h0, rc);
        check("a1_rd_ready_cycle", 32'(rc), 32'd3);
        check("a1_rd_rdata", bus1.read_data, 32'h12345678);

        // Both enables: write wins, read_data untouched
        op(0, 1'b1, 1'b0, 32'd1040, 32'hAAAA5555, rc);
        op(0, 1'b1, 1'b1, 32'd1040, 32'h0000FFFF, rc);
        check("both_ready_cycle", 32'(rc), 32'd5);
        check("both_hw8", 32'(mem0[8]), 32'h00000000);
        check("both_hw9", 32'(mem0[9]), 32'h0000FFFF);
        check("both_rdata_kept", bus0.read_data, 32'hDEADBEEF);

        // Address wrap: 1024 + 4*2^17 maps to word 0
        op(0, 1'b1, 1'b0, 32'd525312, 32'h0BAD0F00, rc);
        check("wrap_addr_hi", 32'(addr_log[1]), 32'd0);
        check("wrap_addr_lo", 32'(addr_log[3]), 32'd1);
        check("wrap_hw0", 32'(mem0[0]), 32'h00000BAD);
        check("wrap_hw1", 32'(mem0[1]), 32'h00000F00);
        op(0, 1'b0, 1'b1, 32'd525312, 32'h0, rc);
        check("wrap_rdata", bus0.read_data, 32'h0BAD0F00);

        // Reset in cycle 2 of a write to halfwords 12/13
        op(0, 1'b1, 1'b0, 32'd1048, 32'h11112222, rc);
        w0 = we_low0;
        drive(0, 1'b1, 1'b0, 32'd1048, 32'hCAFEF00D);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        probe_en = 1'b1;
        #1;
        check("rst_we_n", 32'(we0), 32'd1);
        check("rst_oe_n", 32'(oe0), 32'd1);
        check("rst_dq", 32'(dq0), 32'h0);
        check("rst_addr", 32'(a0), 32'h0);
        check("rst_ready", 32'(bus0.ready), 32'd1);
        check("rst_rdata", bus0.read_data, 32'h0);
        probe_en = 1'b0;
        repeat (3) tick();
        check("rst_hw_hi", 32'(mem0[12]), 32'h0000CAFE);
        check("rst_hw_lo", 32'(mem0[13]), 32'h00002222);
        check("rst_we_low_cycles", 32'(we_low0 - w0), 32'd2);
        op(0, 1'b0, 1'b1, 32'd1048, 32'h0, rc);
        check("post_rst_ready_cycle", 32'(rc), 32'd5);
        check("post_rst_rdata", bus0.read_data, 32'hCAFE2222);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
